// File: rtl/raster_fp_pipes_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raster_fp_pipes_if : operand/result bundle for the raster fp pipelines    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface raster_fp_pipes_if;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_q;
  logic [31:0] add_s;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_q;
  logic [31:0] cvt_a;
  logic [31:0] cvt_q;

  modport master (
    output add_a, add_b, mul_a, mul_b, cvt_a,
    input  add_q, add_s, mul_q, cvt_q
  );

  modport slave (
    input  add_a, add_b, mul_a, mul_b, cvt_a,
    output add_q, add_s, mul_q, cvt_q
  );
endinterface
`default_nettype wire

// File: rtl/raster_fp_pipes.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raster_fp_pipes : binary32 add/sub, multiply and float-to-int pipelines   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module raster_fp_pipes (
  input  logic            clk,
  input  logic            areset,
  raster_fp_pipes_if.slave bus
);

  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam int          ADD_STAGES = 6;
  localparam int          MUL_STAGES = 4;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (|f[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && !(|f[22:0]);
  endfunction

  function automatic logic is_zero(input logic [31:0] f);
    return f[30:23] == 8'd0;
  endfunction

  // m[26] is the leading one; m[2:0] are guard, round and sticky.
  function automatic logic [31:0] round_pack(input logic sign, input int exp_in,
                                             input logic [26:0] m);
    logic        up;
    logic [24:0] r;
    logic [22:0] frac;
    int          e;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + {24'd0, up};
    e  = exp_in;
    if (r[24]) begin
      e    = e + 1;
      frac = r[23:1];
    end else begin
      frac = r[22:0];
    end
    if (e >= 255)
      return {sign, 8'hFF, 23'd0};
    else if (e <= 0)
      return {sign, 31'd0};
    else
      return {sign, e[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        sx, sy;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic [26:0] xm, ym, dif, m;
    logic [53:0] sh;
    logic [27:0] sum;
    int          d, lz;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    if (a[30:0] >= b[30:0]) begin
      {sx, ex, fx} = a;
      {sy, ey, fy} = b;
    end else begin
      {sx, ex, fx} = b;
      {sy, ey, fy} = a;
    end
    d = int'(ex) - int'(ey);
    if (d > 31) d = 31;
    xm = {1'b1, fx, 3'b000};
    sh = {1'b1, fy, 3'b000, 27'd0} >> d;
    ym = {sh[53:28], |sh[27:0]};
    if (sx == sy) begin
      sum = {1'b0, xm} + {1'b0, ym};
      if (sum[27])
        return round_pack(sx, int'(ex) + 1, {sum[27:2], sum[1] | sum[0]});
      return round_pack(sx, int'(ex), sum[26:0]);
    end
    dif = xm - ym;
    if (dif == '0) return 32'd0;
    lz = 0;
    for (int i = 0; i < 27; i++)
      if (dif[i]) lz = 26 - i;
    m = dif << lz;
    return round_pack(sx, int'(ex) - lz, m);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] p;
    int          e;
    sgn = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {sgn, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {sgn, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47])
      return round_pack(sgn, e + 1, {p[47:22], |p[21:0]});
    return round_pack(sgn, e, {p[46:21], |p[20:0]});
  endfunction

  function automatic logic [31:0] fp_to_int(input logic [31:0] a);
    logic [63:0] w;
    logic [31:0] mag;
    logic        up;
    int          e;
    if (is_nan(a)) return 32'd0;
    e = int'(a[30:23]) - 127;
    if (e >= 31) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e < -1) return 32'd0;
    // Integer part lands in w[63:32], fraction in w[31:0].
    w = {8'd0, 1'b1, a[22:0], 32'd0};
    if (e >= 23)
      w = w << (e - 23);
    else
      w = w >> (23 - e);
    up  = w[31] & ((|w[30:0]) | w[32]);
    mag = w[63:32] + {31'd0, up};
    return a[31] ? (~mag + 32'd1) : mag;
  endfunction

  logic [31:0] add_a_reg, add_b_reg, mul_a_reg, mul_b_reg, cvt_a_reg;
  logic [31:0] add_q_pipe [ADD_STAGES];
  logic [31:0] add_s_pipe [ADD_STAGES];
  logic [31:0] mul_pipe   [MUL_STAGES];
  logic [31:0] cvt_reg;
  logic [31:0] add_q_next, add_s_next, mul_next, cvt_next;

  assign add_q_next = fp_add(add_a_reg, add_b_reg);
  assign add_s_next = fp_add(add_a_reg, {~add_b_reg[31], add_b_reg[30:0]});
  assign mul_next   = fp_mul(mul_a_reg, mul_b_reg);
  assign cvt_next   = fp_to_int(cvt_a_reg);

  always_ff @(posedge clk) begin
    if (areset) begin
      add_a_reg <= '0;
      add_b_reg <= '0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      cvt_a_reg <= '0;
      cvt_reg   <= '0;
      for (int i = 0; i < ADD_STAGES; i++) begin
        add_q_pipe[i] <= '0;
        add_s_pipe[i] <= '0;
      end
      for (int i = 0; i < MUL_STAGES; i++)
        mul_pipe[i] <= '0;
    end else begin
      add_a_reg     <= bus.add_a;
      add_b_reg     <= bus.add_b;
      mul_a_reg     <= bus.mul_a;
      mul_b_reg     <= bus.mul_b;
      cvt_a_reg     <= bus.cvt_a;
      cvt_reg       <= cvt_next;
      add_q_pipe[0] <= add_q_next;
      add_s_pipe[0] <= add_s_next;
      mul_pipe[0]   <= mul_next;
      for (int i = 1; i < ADD_STAGES; i++) begin
        add_q_pipe[i] <= add_q_pipe[i-1];
        add_s_pipe[i] <= add_s_pipe[i-1];
      end
      for (int i = 1; i < MUL_STAGES; i++)
        mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  assign bus.add_q = add_q_pipe[ADD_STAGES-1];
  assign bus.add_s = add_s_pipe[ADD_STAGES-1];
  assign bus.mul_q = mul_pipe[MUL_STAGES-1];
  assign bus.cvt_q = cvt_reg;

endmodule
`default_nettype wire

// File: tb/tb_raster_fp_pipes.sv
`default_nettype none
// Directed and random checks of the three raster fp pipelines at their fixed latencies.
module tb_raster_fp_pipes;

  localparam int ADD_LAT = 7;
  localparam int MUL_LAT = 5;
  localparam int CVT_LAT = 2;
  localparam int DEPTH   = 128;

  logic clk = 1'b0;
  logic areset;

  raster_fp_pipes_if bus ();
  raster_fp_pipes dut (.clk(clk), .areset(areset), .bus(bus.slave));

  always #5 clk = ~clk;

  int          cyc, n_checks, n_fail;
  logic [31:0] want_addq [DEPTH];
  logic [31:0] want_adds [DEPTH];
  logic [31:0] want_mul  [DEPTH];
  logic [31:0] want_cvt  [DEPTH];
  bit          has_add   [DEPTH];
  bit          has_mul   [DEPTH];
  bit          has_cvt   [DEPTH];
  string       tag_add   [DEPTH];
  string       tag_mul   [DEPTH];
  string       tag_cvt   [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < DEPTH) begin
      if (has_add[cyc]) begin
        check({tag_add[cyc], " add_q"}, bus.add_q, want_addq[cyc]);
        check({tag_add[cyc], " add_s"}, bus.add_s, want_adds[cyc]);
        has_add[cyc] = 1'b0;
      end
      if (has_mul[cyc]) begin
        check({tag_mul[cyc], " mul_q"}, bus.mul_q, want_mul[cyc]);
        has_mul[cyc] = 1'b0;
      end
      if (has_cvt[cyc]) begin
        check({tag_cvt[cyc], " cvt_q"}, bus.cvt_q, want_cvt[cyc]);
        has_cvt[cyc] = 1'b0;
      end
    end
  endtask

  task automatic expect_add(input int at, input string tag, input logic [31:0] q,
                            input logic [31:0] s);
    if (at < DEPTH) begin
      has_add[at] = 1'b1; want_addq[at] = q; want_adds[at] = s; tag_add[at] = tag;
    end
  endtask

  task automatic expect_mul(input int at, input string tag, input logic [31:0] q);
    if (at < DEPTH) begin
      has_mul[at] = 1'b1; want_mul[at] = q; tag_mul[at] = tag;
    end
  endtask

  task automatic expect_cvt(input int at, input string tag, input logic [31:0] q);
    if (at < DEPTH) begin
      has_cvt[at] = 1'b1; want_cvt[at] = q; tag_cvt[at] = tag;
    end
  endtask

  // One cycle of operands for all three units, with the results each must deliver.
  task automatic issue(input string tag,
                       input logic [31:0] aa, input logic [31:0] ab,
                       input logic [31:0] eq, input logic [31:0] es,
                       input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] em,
                       input logic [31:0] ca, input logic [31:0] ec);
    string t;
    t = $sformatf("%s@c%0d", tag, cyc);
    bus.add_a = aa; bus.add_b = ab;
    bus.mul_a = ma; bus.mul_b = mb;
    bus.cvt_a = ca;
    expect_add(cyc + ADD_LAT, t, eq, es);
    expect_mul(cyc + MUL_LAT, t, em);
    expect_cvt(cyc + CVT_LAT, t, ec);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Operands offered during reset must vanish; every output reads 0 until new work emerges.
  task automatic reset_cycle();
    string t;
    t = $sformatf("rst@c%0d", cyc);
    areset = 1'b1;
    bus.add_a = 32'h3F80_0000; bus.add_b = 32'h3F80_0000;
    bus.mul_a = 32'h4000_0000; bus.mul_b = 32'h4000_0000;
    bus.cvt_a = 32'h4120_0000;
    for (int k = 1; k <= ADD_LAT; k++) expect_add(cyc + k, t, 0, 0);
    for (int k = 1; k <= MUL_LAT; k++) expect_mul(cyc + k, t, 0);
    for (int k = 1; k <= CVT_LAT; k++) expect_cvt(cyc + k, t, 0);
    step();
    areset = 1'b0;
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else                  d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic        up;
    int          fe;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    fe = int'(d[62:52]) - 896;
    up = d[28] & ((|d[27:0]) | d[29]);
    m  = {2'b01, d[51:29]} + {24'd0, up};
    if (m[24]) begin fe = fe + 1; m = m >> 1; end
    if (fe >= 255) return {d[63], 8'hFF, 23'd0};
    if (fe <= 0) return {d[63], 31'd0};
    return {d[63], fe[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] model_cvt(input logic [31:0] f);
    real r, fl, fr;
    int  n;
    r  = f2r(f);
    fl = $floor(r);
    fr = r - fl;
    n  = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && (n % 2 != 0))) n = n + 1;
    return 32'(n);
  endfunction

  function automatic logic [31:0] rand_f(input int lo, input int hi);
    logic [31:0] r;
    r = $urandom();
    return {r[31], 8'($urandom_range(hi, lo)), r[22:0]};
  endfunction

  initial begin
    logic [31:0] aa, ab, ma, mb, ca;
    cyc = 0; n_checks = 0; n_fail = 0;
    areset = 1'b1;
    bus.add_a = 0; bus.add_b = 0; bus.mul_a = 0; bus.mul_b = 0; bus.cvt_a = 0;
    reset_cycle();
    reset_cycle();

    //     tag     add_a         add_b         add_q         add_s         mul_a         mul_b         mul_q         cvt_a         cvt_q
    issue("d1",  32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000, 32'h40400000, 32'hC0200000, 32'hC0F00000, 32'h40200000, 32'h00000002);
    issue("d2",  32'h3F800000, 32'h33800000, 32'h3F800000, 32'h3F7FFFFF, 32'h7F000000, 32'h40000000, 32'h7F800000, 32'h40600000, 32'h00000004);
    issue("d3",  32'h3F800000, 32'h33800001, 32'h3F800001, 32'h3F7FFFFF, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'hBFC00000, 32'hFFFFFFFE);
    issue("d4",  32'h40400000, 32'h40400000, 32'h40C00000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h80000000, 32'h4F32D05E, 32'h7FFFFFFF);
    issue("d5",  32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'hC0000000, 32'hFF800000, 32'h3F000000, 32'h00000000);
    issue("d6",  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'hCF000000, 32'h80000000);
    issue("d7",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00800000, 32'h00800000, 32'h00000000, 32'hFF800000, 32'h80000000);
    issue("d8",  32'h00000001, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h7FC00000, 32'h00000000);
    issue("d9",  32'hBF800000, 32'h3F800000, 32'h00000000, 32'hC0000000, 32'h3F800001, 32'h3F800001, 32'h3F800002, 32'h3F400000, 32'h00000001);
    issue("d10", 32'h3F800001, 32'h33800000, 32'h3F800002, 32'h3F800000, 32'h80000000, 32'hBF800000, 32'h00000000, 32'hBF000000, 32'h00000000);

    for (int i = 0; i < 10; i++) begin
      aa = rand_f(120, 134); ab = rand_f(120, 134);
      ma = rand_f(115, 139); mb = rand_f(115, 139);
      ca = rand_f(110, 146);
      issue("rnd", aa, ab, r2f(f2r(aa) + f2r(ab)), r2f(f2r(aa) - f2r(ab)),
            ma, mb, r2f(f2r(ma) * f2r(mb)), ca, model_cvt(ca));
    end
    idle(8);

    issue("pre1", 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 0, 0, 0);
    issue("pre2", 32'h40000000, 32'h40000000, 0, 0, 0, 0, 0, 0, 0);
    issue("pre3", 32'h40400000, 32'h3F800000, 0, 0, 0, 0, 0, 0, 0);
    reset_cycle();
    idle(2);
    issue("post", 32'h40A00000, 32'h3F800000, 32'h40C00000, 32'h40800000, 0, 0, 0, 0, 0);
    idle(9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
